riscv_ahb3_ext_master: RTL



---
 rtl/riscv_ahb3_ext_master.sv | 111 +++++++++++
 1 files changed

// File: rtl/riscv_ahb3_ext_master.sv
// AHB3-Lite single-transfer master driven by a valid/ready command stream, one in-order response per command.
// Define RISCV_AHB3_MASTER_PIPELINE_EN to overlap the next address phase with the current data phase.
module riscv_ahb3_ext_master #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [PLEN-1:0] cmd_addr,
  input  logic [2:0]      cmd_size,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            ahb3_hsel_o,
  output logic [PLEN-1:0] ahb3_haddr_o,
  output logic [XLEN-1:0] ahb3_hwdata_o,
  output logic            ahb3_hwrite_o,
  output logic [2:0]      ahb3_hsize_o,
  output logic [2:0]      ahb3_hburst_o,
  output logic [3:0]      ahb3_hprot_o,
  output logic [1:0]      ahb3_htrans_o,
  output logic            ahb3_hmastlock_o,
  input  logic [XLEN-1:0] ahb3_hrdata_i,
  input  logic            ahb3_hready_i,
  input  logic            ahb3_hresp_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic            a_vld;
  logic            a_write;
  logic [PLEN-1:0] a_addr;
  logic [2:0]      a_size;
  logic [XLEN-1:0] a_wdata;
  logic            d_vld;
  logic            d_write;
  logic [XLEN-1:0] d_wdata;
  logic            err_hold;
  logic            addr_done;
  logic            data_done;
  logic            cmd_take;

  // ERROR in the data phase (both E1 and E2) suppresses the pending address phase
  assign err_hold  = d_vld & ahb3_hresp_i;
  assign addr_done = a_vld & ~err_hold & ahb3_hready_i;
  assign data_done = d_vld & ahb3_hready_i;

`ifdef RISCV_AHB3_MASTER_PIPELINE_EN
  logic err_e1;
  assign err_e1    = err_hold & ~ahb3_hready_i;
  assign cmd_ready = (~a_vld | addr_done) & ~err_e1;
`else
  assign cmd_ready = ~a_vld & ~d_vld & ~rsp_valid;
`endif

  assign cmd_take = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld     <= 1'b0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_size    <= '0;
      a_wdata   <= '0;
      d_vld     <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (cmd_take) begin
        a_vld   <= 1'b1;
        a_write <= cmd_write;
        a_addr  <= cmd_addr;
        a_size  <= cmd_size;
        a_wdata <= cmd_wdata;
      end else if (addr_done) begin
        a_vld <= 1'b0;
      end

      if (addr_done) begin
        d_vld   <= 1'b1;
        d_write <= a_write;
        d_wdata <= a_wdata;
      end else if (data_done) begin
        d_vld <= 1'b0;
      end

      rsp_valid <= data_done;
      rsp_err   <= data_done & ahb3_hresp_i;
      rsp_rdata <= (data_done & ~d_write) ? ahb3_hrdata_i : '0;
    end
  end

  assign ahb3_hsel_o      = a_vld;
  assign ahb3_haddr_o     = a_addr;
  assign ahb3_hwrite_o    = a_write;
  assign ahb3_hsize_o     = a_size;
  assign ahb3_htrans_o    = (a_vld & ~err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb3_hwdata_o    = d_wdata;
  assign ahb3_hburst_o    = 3'b000;
  assign ahb3_hprot_o     = 4'b0011;
  assign ahb3_hmastlock_o = 1'b0;

endmodule
